// File: rtl/buf_arb_pkg.sv
// Shared types and sizes for the page buffer arbiter.
// Imported by the beat counter and the arbiter top.
package buf_arb_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int BUF_DEPTH  = 2048;
    localparam int ADDR_WIDTH = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        HOST_XFER,
        CNTRL_XFER,
        DONE
    } state_t;

    typedef enum logic {
        OWN_HOST  = 1'b0,
        OWN_CNTRL = 1'b1
    } owner_t;

endpackage

// File: rtl/buf_beat_counter.sv
// Page beat counter shared by both sides; doubles as buffer address.
// Clear has priority over enable; wraps naturally after BUF_DEPTH-1.
module buf_beat_counter
    import buf_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    output logic [ADDR_WIDTH-1:0] o_cnt,
    output logic                  o_tc
);

    logic [ADDR_WIDTH-1:0] r_cnt;

    // Count beats, clear on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == ADDR_WIDTH'(BUF_DEPTH - 1));

endmodule

// File: rtl/page_buf_arbiter.sv
// Host / NAND controller page buffer arbiter and sequencer.
// Optional stall abort enabled by defining BUF_ARB_TIMEOUT_EN.
module page_buf_arbiter
    import buf_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic                  host_valid,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  cntrl_req,
    input  logic                  cntrl_wr,
    input  logic                  cntrl_valid,
    input  logic [DATA_WIDTH-1:0] cntrl_wdata,
    output logic                  host_grant,
    output logic                  cntrl_grant,
    output logic                  host_done,
    output logic                  cntrl_done,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  page_valid,
    output logic                  page_src,
    output logic                  abort_err,
    output logic                  timeout_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t r_state;
    state_t w_state_nxt;
    owner_t r_last;
    owner_t r_src;
    logic   r_wr;
    logic   r_pv;
    logic   r_abort;

    logic                  w_host_elig;
    logic                  w_cntrl_elig;
    logic                  w_act;
    logic                  w_req;
    logic                  w_valid;
    logic                  w_gnt_host;
    logic                  w_gnt_cntrl;
    logic                  w_abort;
    logic                  w_fin;
    logic                  w_stall_hit;
    logic [ADDR_WIDTH-1:0] w_cnt;
    logic                  w_tc;

    // A read is only eligible for a full page written by the other side.
    assign w_host_elig  = host_req &
                          (host_wr | (r_pv & (r_src == OWN_CNTRL)));
    assign w_cntrl_elig = cntrl_req &
                          (cntrl_wr | (r_pv & (r_src == OWN_HOST)));

    assign host_grant  = (r_state == HOST_XFER);
    assign cntrl_grant = (r_state == CNTRL_XFER);
    assign w_act       = host_grant | cntrl_grant;

    assign w_req   = host_grant ? host_req : cntrl_req;
    assign w_valid = host_grant  ? host_valid  :
                     cntrl_grant ? cntrl_valid : 1'b0;

    assign buf_wdata = host_grant  ? host_wdata  :
                       cntrl_grant ? cntrl_wdata : '0;
    assign buf_we    = w_act & w_valid & r_wr;
    assign buf_addr  = w_cnt;

    assign host_done  = (r_state == DONE) && (r_last == OWN_HOST);
    assign cntrl_done = (r_state == DONE) && (r_last == OWN_CNTRL);
    assign page_valid = r_pv;
    assign page_src   = r_src;
    assign abort_err  = r_abort;

`ifdef BUF_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] r_stall;
    logic               r_to;

    assign w_stall_hit = w_act & ~w_valid &
                         (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_to;

    // Count consecutive granted cycles without a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_to    <= 1'b0;
        end else begin
            r_to <= w_stall_hit;
            if (!w_act || w_valid || w_stall_hit) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end
`else
    assign w_stall_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state: arbitration in IDLE, completion or abort in XFER.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_host  = 1'b0;
        w_gnt_cntrl = 1'b0;
        w_abort     = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_host_elig &&
                    (!w_cntrl_elig || r_last == OWN_CNTRL)) begin
                    w_state_nxt = HOST_XFER;
                    w_gnt_host  = 1'b1;
                end else if (w_cntrl_elig) begin
                    w_state_nxt = CNTRL_XFER;
                    w_gnt_cntrl = 1'b1;
                end
            end
            HOST_XFER, CNTRL_XFER: begin
                if (!w_req || w_stall_hit) begin
                    w_state_nxt = IDLE;
                    w_abort     = 1'b1;
                end else if (w_valid && w_tc) begin
                    w_state_nxt = DONE;
                    w_fin       = 1'b1;
                end
            end
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ownership history, transfer direction and page status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= OWN_CNTRL;
            r_src   <= OWN_HOST;
            r_wr    <= 1'b0;
            r_pv    <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (w_gnt_host) begin
                r_last <= OWN_HOST;
                r_wr   <= host_wr;
                if (host_wr) r_pv <= 1'b0;
            end
            if (w_gnt_cntrl) begin
                r_last <= OWN_CNTRL;
                r_wr   <= cntrl_wr;
                if (cntrl_wr) r_pv <= 1'b0;
            end
            if (w_fin) begin
                r_pv <= r_wr;
                if (r_wr) r_src <= r_last;
            end
        end
    end

    buf_beat_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_abort),
        .i_en  (w_act & w_valid & ~w_abort),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

endmodule

// File: tb/tb_page_buf_arbiter.sv
// Scoreboard bench for page_buf_arbiter: random data and valid gaps,
// expected beats/done pulses queued by stimulus, popped by a monitor.
`timescale 1ns/1ps
module tb_page_buf_arbiter;
    import buf_arb_pkg::*;

    typedef struct {
        int              addr;
        bit              we;
        logic [15:0]     d;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic host_req = 0, host_wr = 0, host_valid = 0;
    logic cntrl_req = 0, cntrl_wr = 0, cntrl_valid = 0;
    logic [15:0] host_wdata = '0, cntrl_wdata = '0;
    logic host_grant, cntrl_grant, host_done, cntrl_done;
    logic buf_we, page_valid, page_src, abort_err, timeout_err;
    logic [10:0] buf_addr;
    logic [15:0] buf_wdata;

    int n_checks = 0;
    int n_errors = 0;
    int gseq = 0;
    bit m_pv = 0;
    bit m_src = 0;
    beat_t expq[$];
    bit donq[$];

    page_buf_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_wr(host_wr),
        .host_valid(host_valid), .host_wdata(host_wdata),
        .cntrl_req(cntrl_req), .cntrl_wr(cntrl_wr),
        .cntrl_valid(cntrl_valid), .cntrl_wdata(cntrl_wdata),
        .host_grant(host_grant), .cntrl_grant(cntrl_grant),
        .host_done(host_done), .cntrl_done(cntrl_done),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .page_valid(page_valid), .page_src(page_src),
        .abort_err(abort_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic gnt(input bit s);
        return s ? cntrl_grant : host_grant;
    endfunction

    function automatic logic dn(input bit s);
        return s ? cntrl_done : host_done;
    endfunction

    task automatic drive_req(input bit s, input bit r, input bit w);
        if (s) begin cntrl_req = r; cntrl_wr = w; end
        else begin host_req = r; host_wr = w; end
    endtask

    task automatic drive_beat(input bit s, input bit v,
                              input logic [15:0] d);
        if (s) begin cntrl_valid = v; cntrl_wdata = d; end
        else begin host_valid = v; host_wdata = d; end
    endtask

    task automatic all_zero(input string nm);
        chk(nm, {host_grant, cntrl_grant, host_done, cntrl_done,
                 buf_we, page_valid, page_src, abort_err,
                 timeout_err, buf_addr, buf_wdata}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        all_zero("rst_outs");
        expq.delete();
        donq.delete();
        m_pv = 0;
        m_src = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // mode 0: full page, 1: drop req at stop_at, 2: reset at stop_at
    task automatic xfer(input bit s, input bit w, input int mode,
                        input int stop_at, input int gap,
                        input int exp_lat, output int seq);
        int lat;
        int k;
        logic [15:0] d;
        seq = -1;
        drive_req(s, 1'b1, w);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!gnt(s) && lat < 8000);
        chk("gnt_seen", gnt(s), 1);
        if (!gnt(s)) begin
            drive_req(s, 1'b0, w);
            return;
        end
        seq = gseq;
        gseq++;
        if (exp_lat > 0) chk("gnt_lat", lat, exp_lat);
        if (w) m_pv = 0;
        chk("pv_at_gnt", page_valid, m_pv);
        k = 0;
        while (k < BUF_DEPTH && !(mode != 0 && k == stop_at)) begin
            if ($urandom_range(99) < gap) begin
                drive_beat(s, 1'b0, 16'($urandom));
            end else begin
                d = 16'($urandom);
                drive_beat(s, 1'b1, d);
                expq.push_back('{k, w, d});
                k++;
                if (k == BUF_DEPTH) donq.push_back(s);
            end
            @(posedge clk); #1;
        end
        drive_beat(s, 1'b0, '0);
        if (mode == 2) begin
            #2 rst_n = 1'b0;
            #1 all_zero("rst_mid");
            expq.delete();
            donq.delete();
            m_pv = 0;
            m_src = 0;
            drive_req(s, 1'b0, w);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else if (mode == 1) begin
            drive_req(s, 1'b0, w);
            @(posedge clk); #1;
            chk("abort_pulse", abort_err, 1);
            chk("abort_gnt", gnt(s), 0);
            chk("abort_pv", page_valid, m_pv);
            @(posedge clk); #1;
            chk("abort_1cyc", abort_err, 0);
        end else begin
            chk("done_pulse", dn(s), 1);
            chk("done_gnt", gnt(s), 0);
            if (w) begin m_pv = 1; m_src = s; end
            else m_pv = 0;
            chk("done_pv", page_valid, m_pv);
            if (m_pv) chk("done_src", page_src, m_src);
            @(posedge clk); #1;
            chk("done_1cyc", dn(s), 0);
            drive_req(s, 1'b0, w);
        end
    endtask

    // Monitor: pop an expected beat for every granted valid cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((host_grant && host_valid) ||
                (cntrl_grant && cntrl_valid)) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL beat_unexp addr %0d", buf_addr);
                end else begin
                    beat_t e;
                    e = expq.pop_front();
                    chk("beat_addr", buf_addr, e.addr);
                    chk("beat_we", buf_we, e.we);
                    chk("beat_wdata", buf_wdata, e.d);
                end
            end else begin
                chk("idle_we", buf_we, 0);
            end
            if (host_done || cntrl_done) begin
                if (donq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL done_unexp h %0d c %0d",
                             host_done, cntrl_done);
                end else begin
                    chk("done_side", cntrl_done, donq.pop_front());
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, cs, n;
        do_reset();

        // valid without grant does nothing
        host_valid = 1;
        cntrl_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("nogrant_we", buf_we, 0);
        chk("nogrant_addr", buf_addr, 0);
        host_valid = 0;
        cntrl_valid = 0;

        xfer(0, 1, 0, 0, 0, 1, hs);
        xfer(1, 0, 0, 0, 20, 1, cs);
        chk("cons_pv", page_valid, 0);

        // host read ineligible, cntrl write goes first
        fork
            xfer(0, 0, 0, 0, 10, 0, hs);
            xfer(1, 1, 0, 0, 10, 1, cs);
        join
        chk("elig_order", cs < hs, 1);

        // tie after reset: host wins, then cntrl
        do_reset();
        fork
            xfer(0, 1, 0, 0, 5, 1, hs);
            xfer(1, 1, 0, 0, 5, 0, cs);
        join
        chk("tie_order", hs < cs, 1);

        xfer(0, 1, 1, 100, 15, 1, hs);
        chk("abort_pv0", page_valid, 0);
        xfer(0, 1, 0, 0, 10, 1, hs);

        xfer(0, 1, 2, 500, 10, 1, hs);
        chk("post_rst_pv", page_valid, 0);

        // stall with valid held low
        drive_req(0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("stall_gnt", host_grant, 1);
`ifdef BUF_ARB_TIMEOUT_EN
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (timeout_err) begin n = i; break; end
        end
        chk("to_cycle", n, 256);
        chk("to_abort", abort_err, 1);
        chk("to_gnt", host_grant, 0);
        drive_req(0, 1'b0, 1'b1);
`else
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (timeout_err || !host_grant) n++;
        end
        chk("stall_hold", n, 0);
        drive_req(0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("stall_abort", abort_err, 1);
        chk("stall_to", timeout_err, 0);
`endif
        @(posedge clk); #1;
        chk("expq_empty", expq.size(), 0);
        chk("donq_empty", donq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
